branch_history_table: RTL and testbench

- Direct-mapped branch history table (BHT). It is looked up combinationally by the fetch-stage PC and returns a hit flag, a 2-bit saturating prediction and a stored target.
- It sits directly downstream of the branch-prediction controller. The controller consumes read/prediction and writes back updated_logic under write.
- A one-entry write buffer with lookup bypass, plus a clear-sweep FSM, provide the sequential behaviour.

---
 rtl/bht_pkg.sv | 36 +++
 rtl/bht_sweep_fsm.sv | 69 ++++++
 rtl/branch_history_table.sv | 183 ++++++++++++++++++
 tb/tb_branch_history_table.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and defaults for the branch history table.
// Optional statistics counters are compiled in with the BHT_STATS_EN macro.
package bht_pkg;

    // 2-bit saturating counter encoding stored per entry
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    // Sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bht_state_t;

    // Default geometry of the table
    localparam int unsigned BHT_DEF_XLEN    = 32;
    localparam int unsigned BHT_DEF_ENTRIES = 16;
    localparam int unsigned BHT_DEF_TAG_W   = BHT_DEF_XLEN - $clog2(BHT_DEF_ENTRIES) - 2;

    // Prediction returned whenever a lookup misses
    localparam bht_ctr_t BHT_INIT_STATE = WNT;

    // Entry layout for the default geometry; the top declares the same
    // fields sized from its own parameters
    typedef struct packed {
        logic                     valid;
        logic [BHT_DEF_TAG_W-1:0] tag;
        bht_ctr_t                 ctr;
        logic [BHT_DEF_XLEN-1:0]  tgt;
    } bht_entry_t;

endpackage

// File: rtl/bht_sweep_fsm.sv
// Clear-sweep controller: on a clear pulse in IDLE it walks every table
// index once, one entry per cycle, then returns to IDLE.
// Used inside branch_history_table (stats macro BHT_STATS_EN has no effect here).
module bht_sweep_fsm
    import bht_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    output bht_state_t       state_o,
    output logic             busy_o,
    output logic             clr_en_o,
    output logic [IDX_W-1:0] clr_idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    bht_state_t       state_q;
    bht_state_t       state_d;
    logic [IDX_W-1:0] sweepCnt_q;
    logic [IDX_W-1:0] sweepCnt_d;

    // State and sweep counter registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sweepCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
        end
    end

    // Next-state logic; clear is only honoured from IDLE so a sweep never restarts
    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        clr_en_o   = 1'b0;
        clr_idx_o  = sweepCnt_q;
        busy_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d    = SWEEP;
                    sweepCnt_d = '0;
                end
            end
            SWEEP: begin
                busy_o     = 1'b1;
                clr_en_o   = 1'b1;
                sweepCnt_d = sweepCnt_q + 1'b1;
                if (sweepCnt_q == LAST_IDX) begin
                    state_d    = IDLE;
                    sweepCnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                sweepCnt_d = '0;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table with a one-entry write buffer that is
// bypassed to the lookup port, and a clear sweep that invalidates every entry.
// Define BHT_STATS_EN to add saturating hit/miss/update counters.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned XLEN       = 32,
    parameter bht_ctr_t    INIT_STATE = BHT_INIT_STATE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc1,
    input  logic            fetch_en,
    output logic            read,
    output logic [1:0]      prediction,
    output logic [XLEN-1:0] target,
    input  logic            write,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      updated_logic,
    input  logic [XLEN-1:0] upd_target,
    input  logic            clear,
    output logic            busy
`ifdef BHT_STATS_EN
    ,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     miss_cnt,
    output logic [15:0]     upd_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        bht_ctr_t         ctr;
        logic [XLEN-1:0]  tgt;
    } entry_t;

    logic [IDX_W-1:0] lkIdx;
    logic [TAG_W-1:0] lkTag;
    logic [IDX_W-1:0] upIdx;
    logic [TAG_W-1:0] upTag;

    bht_state_t       state;
    logic             clrEn;
    logic [IDX_W-1:0] clrIdx;
    logic             sweepBusy;

    logic             clearStart;
    logic             writeAccept;
    logic             commit;

    logic [ENTRIES-1:0] valid_q;
    entry_t             table_q [ENTRIES];

    logic             wbValid_q;
    logic             wbValid_d;
    logic [IDX_W-1:0] wbIdx_q;
    logic [TAG_W-1:0] wbTag_q;
    bht_ctr_t         wbCtr_q;
    logic [XLEN-1:0]  wbTgt_q;

    entry_t           arrEntry;
    logic             arrHit;
    logic             wbHit;

    logic             unused_pcLowBits;

    assign lkIdx = pc1[IDX_W+1:2];
    assign lkTag = pc1[XLEN-1:IDX_W+2];
    assign upIdx = upd_pc[IDX_W+1:2];
    assign upTag = upd_pc[XLEN-1:IDX_W+2];

    bht_sweep_fsm #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_sweep (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (clear),
        .state_o   (state),
        .busy_o    (sweepBusy),
        .clr_en_o  (clrEn),
        .clr_idx_o (clrIdx)
    );

    assign busy = sweepBusy;

    // A clear in IDLE beats a simultaneous write and drops whatever is buffered
    assign clearStart  = clear && (state == IDLE);
    assign writeAccept = write && (state == IDLE) && !clear;
    assign commit      = wbValid_q && !clearStart;
    assign wbValid_d   = writeAccept;

    // Valid bits and buffer-valid flag are the only state that needs reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            wbValid_q <= 1'b0;
        end else begin
            wbValid_q <= wbValid_d;
            if (clrEn) begin
                valid_q[clrIdx] <= 1'b0;
            end else if (commit) begin
                valid_q[wbIdx_q] <= 1'b1;
            end
        end
    end

    // Capture an accepted update into the write buffer
    always_ff @(posedge clk) begin
        if (writeAccept) begin
            wbIdx_q <= upIdx;
            wbTag_q <= upTag;
            wbCtr_q <= bht_ctr_t'(updated_logic);
            wbTgt_q <= upd_target;
        end
    end

    // Retire the buffered update into the array, replacing any older tag
    always_ff @(posedge clk) begin
        if (commit) begin
            table_q[wbIdx_q] <= '{tag: wbTag_q, ctr: wbCtr_q, tgt: wbTgt_q};
        end
    end

    // Zero-latency lookup; a full tag match in the buffer takes priority over the array
    always_comb begin
        arrEntry   = table_q[lkIdx];
        arrHit     = valid_q[lkIdx] && (arrEntry.tag == lkTag);
        wbHit      = wbValid_q && (wbIdx_q == lkIdx) && (wbTag_q == lkTag);
        read       = 1'b0;
        prediction = INIT_STATE;
        target     = '0;
        if (state == IDLE) begin
            if (wbHit) begin
                read       = 1'b1;
                prediction = wbCtr_q;
                target     = wbTgt_q;
            end else if (arrHit) begin
                read       = 1'b1;
                prediction = arrEntry.ctr;
                target     = arrEntry.tgt;
            end
        end
    end

`ifdef BHT_STATS_EN
    logic [15:0] hitCnt_q;
    logic [15:0] missCnt_q;
    logic [15:0] updCnt_q;

    // Saturating lookup and update statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
            updCnt_q  <= '0;
        end else begin
            if (fetch_en && read && (hitCnt_q != 16'hFFFF)) begin
                hitCnt_q <= hitCnt_q + 16'd1;
            end
            if (fetch_en && !read && (missCnt_q != 16'hFFFF)) begin
                missCnt_q <= missCnt_q + 16'd1;
            end
            if (writeAccept && (updCnt_q != 16'hFFFF)) begin
                updCnt_q <= updCnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hitCnt_q;
    assign miss_cnt = missCnt_q;
    assign upd_cnt  = updCnt_q;

    assign unused_pcLowBits = ^{pc1[1:0], upd_pc[1:0]};
`else
    assign unused_pcLowBits = ^{pc1[1:0], upd_pc[1:0], fetch_en};
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: stimulus pushes the lookup
// expected from a behavioural table model, a negedge monitor pops and compares.
// Counter outputs are checked when BHT_STATS_EN is defined.
module tb_branch_history_table;

    localparam int NENT = 16;

    typedef struct packed {
        logic        rd;
        logic [1:0]  pred;
        logic [31:0] tgt;
        logic        bsy;
        logic [15:0] h;
        logic [15:0] m;
        logic [15:0] u;
    } expT;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] tag;
        logic [1:0]  ctr;
        logic [31:0] tgt;
    } pendT;

    logic        clk;
    logic        rst;
    logic [31:0] pc1;
    logic        fetchEn;
    logic        read;
    logic [1:0]  prediction;
    logic [31:0] target;
    logic        write;
    logic [31:0] updPc;
    logic [1:0]  updatedLogic;
    logic [31:0] updTarget;
    logic        clear;
    logic        busy;
`ifdef BHT_STATS_EN
    logic [15:0] hitCnt;
    logic [15:0] missCnt;
    logic [15:0] updCnt;
`endif

    int passCount  = 0;
    int totalCount = 0;

    expT  expQ[$];

    // behavioural model: whole-table view plus in-flight updates
    logic        mValid[NENT];
    logic [31:0] mTag[NENT];
    logic [1:0]  mCtr[NENT];
    logic [31:0] mTgt[NENT];
    pendT        pendQ[$];
    int          sweepLeft;
    logic [15:0] hitM, missM, updM;

    branch_history_table dut (
        .clk           (clk),
        .rst           (rst),
        .pc1           (pc1),
        .fetch_en      (fetchEn),
        .read          (read),
        .prediction    (prediction),
        .target        (target),
        .write         (write),
        .upd_pc        (updPc),
        .updated_logic (updatedLogic),
        .upd_target    (updTarget),
        .clear         (clear),
        .busy          (busy)
`ifdef BHT_STATS_EN
        ,
        .hit_cnt       (hitCnt),
        .miss_cnt      (missCnt),
        .upd_cnt       (updCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] idxOf(input logic [31:0] pc);
        return (pc >> 2) % NENT;
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] pc);
        return pc / (NENT * 4);
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NENT; i++) mValid[i] = 1'b0;
        pendQ.delete();
        sweepLeft = 0;
        hitM = '0; missM = '0; updM = '0;
    endtask

    function automatic expT modelLookup(input logic [31:0] pc);
        expT e;
        logic found;
        logic [31:0] ix, tg;
        ix = idxOf(pc);
        tg = tagOf(pc);
        e.rd = 1'b0; e.pred = 2'b01; e.tgt = '0;
        e.bsy = (sweepLeft > 0);
        e.h = hitM; e.m = missM; e.u = updM;
        found = 1'b0;
        if (sweepLeft == 0) begin
            for (int i = pendQ.size() - 1; i >= 0; i--) begin
                if (!found && pendQ[i].idx == ix && pendQ[i].tag == tg) begin
                    found = 1'b1;
                    e.rd = 1'b1; e.pred = pendQ[i].ctr; e.tgt = pendQ[i].tgt;
                end
            end
            if (!found && mValid[ix] && mTag[ix] == tg) begin
                e.rd = 1'b1; e.pred = mCtr[ix]; e.tgt = mTgt[ix];
            end
        end
        return e;
    endfunction

    task automatic modelEdge(input logic wr, input logic [31:0] upc, input logic [1:0] uctr,
                             input logic [31:0] utgt, input logic clr, input logic fe,
                             input logic rdSeen);
        pendT p;
        if (fe) begin
            if (rdSeen) hitM = satInc(hitM);
            else        missM = satInc(missM);
        end
        if (sweepLeft > 0) begin
            sweepLeft--;
        end else if (clr) begin
            for (int i = 0; i < NENT; i++) mValid[i] = 1'b0;
            pendQ.delete();
            sweepLeft = NENT;
        end else begin
            while (pendQ.size() > 0) begin
                p = pendQ.pop_front();
                mValid[p.idx] = 1'b1;
                mTag[p.idx]   = p.tag;
                mCtr[p.idx]   = p.ctr;
                mTgt[p.idx]   = p.tgt;
            end
            if (wr) begin
                p.idx = idxOf(upc); p.tag = tagOf(upc); p.ctr = uctr; p.tgt = utgt;
                pendQ.push_back(p);
                updM = satInc(updM);
            end
        end
    endtask

    // called at posedge+1: drive one cycle, queue expectation, advance model across the edge
    task automatic applyStimulus(input logic [31:0] pc, input logic wr, input logic [31:0] upc,
                                 input logic [1:0] uctr, input logic [31:0] utgt,
                                 input logic clr, input logic fe);
        expT e;
        pc1 = pc; write = wr; updPc = upc; updatedLogic = uctr;
        updTarget = utgt; clear = clr; fetchEn = fe;
        e = modelLookup(pc);
        expQ.push_back(e);
        @(posedge clk);
        modelEdge(wr, upc, uctr, utgt, clr, fe, e.rd);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(pc, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        totalCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic checkOutput(input expT e);
        checkField("read", {31'b0, read}, {31'b0, e.rd});
        checkField("prediction", {30'b0, prediction}, {30'b0, e.pred});
        checkField("target", target, e.tgt);
        checkField("busy", {31'b0, busy}, {31'b0, e.bsy});
`ifdef BHT_STATS_EN
        checkField("hit_cnt", {16'b0, hitCnt}, {16'b0, e.h});
        checkField("miss_cnt", {16'b0, missCnt}, {16'b0, e.m});
        checkField("upd_cnt", {16'b0, updCnt}, {16'b0, e.u});
`endif
    endtask

    // monitor: outputs are valid every cycle, compared away from the active edge
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        expT e;
        logic [31:0] rpc, rupc;
        rst = 1'b0; pc1 = '0; write = 1'b0; updPc = '0; updatedLogic = '0;
        updTarget = '0; clear = 1'b0; fetchEn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        lookup(32'h40);
        // write then bypass then array
        applyStimulus(32'h40, 1'b1, 32'h40, 2'b11, 32'h100, 1'b0, 1'b1);
        lookup(32'h40);
        lookup(32'h40);
        // aliasing replacement at index 0
        applyStimulus(32'h40, 1'b1, 32'h40, 2'b10, 32'h200, 1'b0, 1'b0);
        applyStimulus(32'h40, 1'b1, 32'h440, 2'b01, 32'h300, 1'b0, 1'b0);
        lookup(32'h440);
        lookup(32'h40);
        lookup(32'h440);
        // back-to-back writes
        applyStimulus(32'h0, 1'b1, 32'h40, 2'b01, 32'h500, 1'b0, 1'b0);
        applyStimulus(32'h0, 1'b1, 32'h44, 2'b10, 32'h600, 1'b0, 1'b0);
        lookup(32'h0);
        lookup(32'h40);
        lookup(32'h44);
        // clear sweep with a dropped write mid-sweep
        applyStimulus(32'h40, 1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < NENT; i++) begin
            if (i == 5) applyStimulus(32'h40, 1'b1, 32'h40, 2'b11, 32'h700, 1'b1, 1'b1);
            else lookup(32'h40);
        end
        lookup(32'h40);
        lookup(32'h44);
        // asynchronous reset part-way through a sweep
        applyStimulus(32'h44, 1'b1, 32'h44, 2'b11, 32'h800, 1'b0, 1'b1);
        applyStimulus(32'h44, 1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b1);
        repeat (7) lookup(32'h44);
        write = 1'b0; clear = 1'b0; fetchEn = 1'b0; pc1 = 32'h44;
        rst = 1'b0;
        #1;
        modelReset();
        e = modelLookup(32'h44);
        expQ.push_back(e);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        modelEdge(1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, e.rd);
        #1;
        lookup(32'h44);
        lookup(32'h40);

        // randomized traffic over a small address pool
        for (int n = 0; n < 500; n++) begin
            rpc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rupc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            applyStimulus(rpc, 1'($urandom_range(0, 1)), rupc, 2'($urandom_range(0, 3)),
                          $urandom, 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            totalCount++;
            $display("[TB] FAIL drain: actual=%0d required=0 pending expectations", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
